// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scan driver.
//   SEG_OFF     all segments dark (active-low lines, a..g)
//   SEG_GLYPH   hex glyph table indexed by nibble, bit order [0:6] = a..g, 0 = lit
//   hex_to_seg  nibble -> segment pattern lookup
package seg7_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    localparam logic [0:6] SEG_GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
        return SEG_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_prescaler.sv
// seg7_scan_prescaler: slot counter for the digit scan.
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   en         in   count enable (held low for the first edge after reset release)
//   pcnt_next  out  value pcnt takes on the coming edge
//   tick       out  pcnt == PRESCALE-1 while enabled (last cycle of a slot)
module seg7_scan_prescaler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    output logic [CW-1:0] pcnt_next,
    output logic          tick
);

    logic [CW-1:0] pcnt_q;

    always_comb begin
        tick      = en && (pcnt_q == CW'(PRESCALE - 1));
        pcnt_next = pcnt_q;
        if (en) begin
            pcnt_next = tick ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_next;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode hex digits.
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   value       in   4*NUM_DIGITS hex nibbles, nibble k -> digit k
//   load        in   strobe: copy value into the shadow register
//   blank_mask  in   bit k forces digit k dark (sampled live)
//   seg         out  segment lines a..g, active-low, registered
//   an          out  digit enables, active-low, registered
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to keep leading zero digits dark
// (digit 0 is always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // run_q holds the scan still for the first edge after reset release.
    logic                    run_q;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           pcnt_next;
    logic                    tick;
    logic                    guard;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [0:6]              seg_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                    leading;
`endif

    seg7_scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CW       (PW)
    ) u_prescaler (
        .clk       (clk),
        .resetn    (resetn),
        .en        (run_q),
        .pcnt_next (pcnt_next),
        .tick      (tick)
    );

    always_comb begin
        shadow_d = load ? value : shadow_q;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        suppress = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; stay dark until the first non-zero nibble.
        leading = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (shadow_d[4*k +: 4] != 4'h0) begin
                leading = 1'b0;
            end
            suppress[k] = leading;
        end
`endif

        // Outputs are registered, so decode from next-state pcnt/idx/shadow.
        guard = (32'(pcnt_next) < BLANK_CYCLES);
        dark  = guard || blank_mask[idx_d] || suppress[idx_d];
        an_d  = dark ? '1 : ~(NUM_DIGITS'(1) << idx_d);
        seg_d = dark ? SEG_OFF : hex_to_seg(shadow_d[4*idx_d +: 4]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            shadow_q <= '0;
            idx_q    <= '0;
            an       <= '1;
            seg      <= SEG_OFF;
        end else begin
            run_q    <= 1'b1;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            an       <= an_d;
            seg      <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized self-checking bench for seg7_scan_driver
// (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1). Honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 1;

    logic        clk;
    logic        resetn;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [0:6]  seg;
    logic [3:0]  an;

    // Reference model state: edges since reset release, shadow, mask seen at last edge.
    int          t;
    logic [15:0] sh;
    logic [3:0]  m;
    int          checks;
    int          failures;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [0:6] glyph(input int h);
        case (h)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0001100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Edge t after release shows position p=t-1 of the scan: cycle p%P of slot (p/P)%N.
    function automatic void expect_out(output logic [3:0] ean, output logic [0:6] eseg);
        int p;
        int pc;
        int ix;
        bit dk;
        ean  = 4'hF;
        eseg = 7'b1111111;
        if (t == 0) return;
        p  = t - 1;
        pc = p % P;
        ix = (p / P) % N;
        dk = (pc < B) || (m[ix] == 1'b1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (ix > 0 && (sh >> (4 * ix)) == 16'h0) dk = 1'b1;
`endif
        if (!dk) begin
            ean  = ~(4'b0001 << ix);
            eseg = glyph(int'((sh >> (4 * ix)) & 16'hF));
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (resetn) begin
            t++;
            if (load) sh = value;
            m = blank_mask;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        value      = '0;
        load       = 1'b0;
        blank_mask = '0;
        t  = 0;
        sh = '0;
        m  = '0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (an !== 4'hF || seg !== 7'b1111111) begin
            failures++;
            $display("FAIL reset_state an=%b seg=%b required an=1111 seg=1111111", an, seg);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_scan_12af();
        logic [3:0] ea;
        logic [0:6] es;
        int lit [4];
        for (int k = 0; k < 4; k++) lit[k] = 0;
        value = 16'h12AF;
        load  = 1'b1;
        step();
        load = 1'b0;
        expect_out(ea, es);
        checks++;
        if (an !== ea || seg !== es) begin
            failures++;
            $display("FAIL first_edge an=%b seg=%b required an=%b seg=%b", an, seg, ea, es);
        end
        for (int i = 0; i < 2 * N * P; i++) begin
            step();
            expect_out(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL scan_12af t=%0d an=%b seg=%b required an=%b seg=%b",
                         t, an, seg, ea, es);
            end
            for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) lit[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lit[k] !== 2 * (P - B)) begin
                failures++;
                $display("FAIL lit_cycles digit=%0d got=%0d required=%0d", k, lit[k], 2 * (P - B));
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [3:0] ea;
        logic [0:6] es;
        blank_mask = 4'b0100;
        value      = 16'h8888;
        load       = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < N * P + P; i++) begin
            step();
            expect_out(ea, es);
            checks++;
            if (an !== ea || seg !== es || an === 4'b1011) begin
                failures++;
                $display("FAIL blank_mask t=%0d an=%b seg=%b required an=%b seg=%b",
                         t, an, seg, ea, es);
            end
        end
        blank_mask = 4'b0000;
    endtask

    task automatic test_leading_zero();
        logic [3:0] ea;
        logic [0:6] es;
        int upper;
        int req;
        logic [15:0] vals [2];
        vals[0] = 16'h0003;
        vals[1] = 16'h0000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        req = 0;
`else
        req = 3 * (P - B);
`endif
        for (int v = 0; v < 2; v++) begin
            upper = 0;
            value = vals[v];
            load  = 1'b1;
            step();
            load = 1'b0;
            for (int i = 0; i < N * P; i++) begin
                step();
                expect_out(ea, es);
                checks++;
                if (an !== ea || seg !== es) begin
                    failures++;
                    $display("FAIL leading_zero val=%h t=%0d an=%b seg=%b required an=%b seg=%b",
                             vals[v], t, an, seg, ea, es);
                end
                if (an !== 4'hF && an !== 4'b1110) upper++;
            end
            checks++;
            if (upper !== req) begin
                failures++;
                $display("FAIL upper_digits val=%h lit=%0d required=%0d", vals[v], upper, req);
            end
        end
    endtask

    task automatic test_load_on_tick();
        logic [3:0] ea;
        logic [0:6] es;
        int lit;
        value = 16'h1111;
        load  = 1'b1;
        step();
        load = 1'b0;
        // Advance until the coming edge is the tick edge (current pcnt == P-1).
        for (int i = 0; i < P && !((t - 1) % P == P - 1); i++) step();
        value = 16'h5555;
        load  = 1'b1;
        step();
        load = 1'b0;
        lit  = 0;
        expect_out(ea, es);
        checks++;
        if (an !== ea || seg !== es) begin
            failures++;
            $display("FAIL tick_load_edge an=%b seg=%b required an=%b seg=%b", an, seg, ea, es);
        end
        for (int i = 0; i < P - 1; i++) begin
            step();
            expect_out(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL tick_load t=%0d an=%b seg=%b required an=%b seg=%b",
                         t, an, seg, ea, es);
            end
            if (an !== 4'hF) begin
                lit++;
                checks++;
                if (seg !== 7'b0100100) begin
                    failures++;
                    $display("FAIL tick_load_glyph seg=%b required=0100100", seg);
                end
            end
        end
        checks++;
        if (lit !== P - B) begin
            failures++;
            $display("FAIL tick_load_lit got=%0d required=%0d", lit, P - B);
        end
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [0:6] es;
        for (int i = 0; i < 300; i++) begin
            load       = ($urandom_range(0, 5) == 0);
            value      = 16'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
            expect_out(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL random t=%0d an=%b seg=%b required an=%b seg=%b",
                         t, an, seg, ea, es);
            end
            checks++;
            if ($countones(~an) > 1 || (an === 4'hF && seg !== 7'b1111111)) begin
                failures++;
                $display("FAIL invariant an=%b seg=%b required one-hot-low or dark", an, seg);
            end
        end
        load       = 1'b0;
        blank_mask = 4'h0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea;
        logic [0:6] es;
        value = 16'h9876;
        load  = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * P && an === 4'hF; i++) step();
        checks++;
        if (an === 4'hF) begin
            failures++;
            $display("FAIL reset_mid_setup an=%b required a lit digit", an);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'b1111111) begin
            failures++;
            $display("FAIL async_reset an=%b seg=%b required an=1111 seg=1111111", an, seg);
        end
        t  = 0;
        sh = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < B + 1; i++) begin
            step();
            expect_out(ea, es);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL restart t=%0d an=%b seg=%b required an=%b seg=%b",
                         t, an, seg, ea, es);
            end
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001) begin
            failures++;
            $display("FAIL restart_digit0 an=%b seg=%b required an=1110 seg=0000001", an, seg);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_scan_12af();
        test_blank_mask();
        test_leading_zero();
        test_load_on_tick();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
